apb_dec_mux: RTL and testbench

APB_DEC_MUX -- requirements
Module: apb_dec_mux

---
 rtl/apb_dec_pkg.sv | 21 ++
 rtl/apb_range_match.sv | 30 +++
 rtl/apb_dec_mux.sv | 178 +++++++++++++++++
 tb/tb_apb_dec_mux.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_dec_pkg.sv
// Shared types and helpers for the APB decoder/mux.
package apb_dec_pkg;

  // Transfer sequencing states of the decoder/mux.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  // Width used to compare range bounds independent of the address width.
  localparam int unsigned RANGE_CMP_W = 64;

  // A range takes part in decoding only when its end is not below its start.
  function automatic logic range_valid(input logic [RANGE_CMP_W-1:0] start_addr,
                                       input logic [RANGE_CMP_W-1:0] end_addr);
    return end_addr >= start_addr;
  endfunction

endpackage

// File: rtl/apb_range_match.sv
// Combinational match of one address against all ranges owned by one slave.
module apb_range_match
  import apb_dec_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned RANGE_NUM  = 2,
  parameter logic [RANGE_NUM*ADDR_WIDTH-1:0] START_ADDRS = '0,
  parameter logic [RANGE_NUM*ADDR_WIDTH-1:0] END_ADDRS   = '0
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit
);

  logic [RANGE_NUM-1:0] range_hit;

  generate
    for (genvar gi = 0; gi < RANGE_NUM; gi++) begin : g_range
      logic [ADDR_WIDTH-1:0] lo;
      logic [ADDR_WIDTH-1:0] hi;
      assign lo = START_ADDRS[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign hi = END_ADDRS[gi*ADDR_WIDTH +: ADDR_WIDTH];
      // Inclusive bounds; disabled ranges never hit.
      assign range_hit[gi] = range_valid(RANGE_CMP_W'(lo), RANGE_CMP_W'(hi)) &&
                             (addr >= lo) && (addr <= hi);
    end
  endgenerate

  assign hit = |range_hit;

endmodule

// File: rtl/apb_dec_mux.sv
// APB 1-to-N decoder/mux with per-master visibility, error slot and timeout.
module apb_dec_mux
  import apb_dec_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MASTER_NUM     = 2,
  parameter int unsigned SLAVE_NUM      = 5,
  parameter int unsigned RANGE_NUM      = 2,
  parameter logic [SLAVE_NUM*RANGE_NUM*ADDR_WIDTH-1:0] START_ADDRS = '0,
  parameter logic [SLAVE_NUM*RANGE_NUM*ADDR_WIDTH-1:0] END_ADDRS   = '0,
  parameter logic [MASTER_NUM*SLAVE_NUM-1:0] VISIBLE = '1,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned MID_W = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [MID_W-1:0]                master_id,
  input  logic                            s_psel,
  input  logic                            s_penable,
  input  logic                            s_pwrite,
  input  logic [ADDR_WIDTH-1:0]           s_paddr,
  input  logic [DATA_WIDTH-1:0]           s_pwdata,
  output logic                            s_pready,
  output logic                            s_pslverr,
  output logic [DATA_WIDTH-1:0]           s_prdata,
  output logic [SLAVE_NUM-1:0]            m_psel,
  output logic                            m_penable,
  output logic                            m_pwrite,
  output logic [ADDR_WIDTH-1:0]           m_paddr,
  output logic [DATA_WIDTH-1:0]           m_pwdata,
  input  logic [SLAVE_NUM-1:0]            m_pready,
  input  logic [SLAVE_NUM-1:0]            m_pslverr,
  input  logic [SLAVE_NUM*DATA_WIDTH-1:0] m_prdata
);

  localparam int unsigned SEL_W = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  state_t                  state_reg;
  logic [SEL_W-1:0]        sel_idx_reg;
  logic [SLAVE_NUM-1:0]    m_psel_reg;
  logic                    m_penable_reg;
  logic                    write_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [TO_W-1:0]         cnt_reg;

  logic [SLAVE_NUM-1:0]    range_hit;
  logic [SLAVE_NUM-1:0]    mask_terms [MASTER_NUM];
  logic [SLAVE_NUM-1:0]    vis_mask;
  logic [SLAVE_NUM-1:0]    slave_hit;
  logic [SEL_W-1:0]        hit_idx;
  logic                    sel_ready;
  logic                    timeout_hit;

  // Address decode: one range matcher per slave.
  generate
    for (genvar gi = 0; gi < SLAVE_NUM; gi++) begin : g_match
      apb_range_match #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RANGE_NUM  (RANGE_NUM),
        .START_ADDRS(START_ADDRS[gi*RANGE_NUM*ADDR_WIDTH +: RANGE_NUM*ADDR_WIDTH]),
        .END_ADDRS  (END_ADDRS[gi*RANGE_NUM*ADDR_WIDTH +: RANGE_NUM*ADDR_WIDTH])
      ) u_match (
        .addr(s_paddr),
        .hit (range_hit[gi])
      );
    end

    // An out-of-range master_id matches no term, so its mask is empty.
    for (genvar gi = 0; gi < MASTER_NUM; gi++) begin : g_vis
      assign mask_terms[gi] = (master_id == MID_W'(gi)) ?
                              VISIBLE[gi*SLAVE_NUM +: SLAVE_NUM] : '0;
    end
  endgenerate

  // Merge the visibility masks of all masters (at most one is non-zero).
  always_comb begin
    vis_mask = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      vis_mask = vis_mask | mask_terms[i];
    end
  end

  assign slave_hit = range_hit & vis_mask;

  // Priority encode: overlapping hits go to the lowest slave index.
  always_comb begin
    hit_idx = '0;
    for (int i = SLAVE_NUM - 1; i >= 0; i--) begin
      if (slave_hit[i]) hit_idx = SEL_W'(i);
    end
  end

  assign sel_ready   = m_pready[sel_idx_reg];
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_reg == ST_ACCESS) &&
                       !sel_ready && (cnt_reg == TO_LAST);

  // Transfer FSM with registered downstream controls. master_id only feeds
  // the decode, whose result is captured in sel_idx_reg.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      sel_idx_reg   <= '0;
      m_psel_reg    <= '0;
      m_penable_reg <= 1'b0;
      write_reg     <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      cnt_reg       <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (s_psel && !s_penable) begin
            addr_reg  <= s_paddr;
            write_reg <= s_pwrite;
            wdata_reg <= s_pwdata;
            if (|slave_hit) begin
              sel_idx_reg <= hit_idx;
              m_psel_reg  <= SLAVE_NUM'(1) << hit_idx;
              state_reg   <= ST_SETUP;
            end else begin
              state_reg   <= ST_ERR;
            end
          end
        end
        ST_SETUP: begin
          m_penable_reg <= 1'b1;
          cnt_reg       <= '0;
          state_reg     <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (sel_ready || timeout_hit) begin
            m_psel_reg    <= '0;
            m_penable_reg <= 1'b0;
            cnt_reg       <= '0;
            state_reg     <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Upstream response; an ACCESS response is dropped if the master let go.
  always_comb begin
    s_pready  = 1'b0;
    s_pslverr = 1'b0;
    s_prdata  = '0;
    if (state_reg == ST_ERR) begin
      s_pready  = 1'b1;
      s_pslverr = 1'b1;
    end else if (state_reg == ST_ACCESS && s_psel) begin
      if (timeout_hit) begin
        s_pready  = 1'b1;
        s_pslverr = 1'b1;
      end else begin
        s_pready  = sel_ready;
        s_pslverr = m_pslverr[sel_idx_reg];
        s_prdata  = m_prdata[sel_idx_reg*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign m_psel    = m_psel_reg;
  assign m_penable = m_penable_reg;
  assign m_pwrite  = write_reg;
  assign m_paddr   = addr_reg;
  assign m_pwdata  = wdata_reg;

endmodule

// File: tb/tb_apb_dec_mux.sv
// Bench for apb_dec_mux: directed vector table, hand sequences, random traffic.
module tb_apb_dec_mux;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MN = 3;
  localparam int SN = 5;
  localparam int RN = 2;
  localparam int TO = 16;

  // Flat range tables, entry (slave*RN + range); highest entry first.
  localparam logic [SN*RN*AW-1:0] START_P = {
    32'h0020_0000, 32'h0003_0000,   // slave 4: r1 (disabled), r0
    32'h0000_8000, 32'h0004_0000,   // slave 3: r1 (overlaps slave 0), r0
    32'h0050_0000, 32'h0002_0000,   // slave 2: r1 (disabled), r0
    32'h0010_0000, 32'h0001_0000,   // slave 1
    32'h0060_0000, 32'h0000_0000};  // slave 0
  localparam logic [SN*RN*AW-1:0] END_P = {
    32'h001F_FFFF, 32'h0003_FFFF,
    32'h0000_80FF, 32'h0004_FFFF,
    32'h0000_0000, 32'h0002_FFFF,
    32'h0010_0FFF, 32'h0001_FFFF,
    32'h0060_0003, 32'h0000_FFFF};
  localparam logic [MN*SN-1:0] VIS_P = {5'b10100, 5'b00011, 5'b11111};

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        master_id;
  logic              s_psel, s_penable, s_pwrite;
  logic [AW-1:0]     s_paddr;
  logic [DW-1:0]     s_pwdata;
  logic              s_pready, s_pslverr;
  logic [DW-1:0]     s_prdata;
  logic [SN-1:0]     m_psel;
  logic              m_penable, m_pwrite;
  logic [AW-1:0]     m_paddr;
  logic [DW-1:0]     m_pwdata;
  logic [SN-1:0]     m_pready, m_pslverr;
  logic [SN*DW-1:0]  m_prdata;

  apb_dec_mux #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASTER_NUM(MN), .SLAVE_NUM(SN),
    .RANGE_NUM(RN), .START_ADDRS(START_P), .END_ADDRS(END_P),
    .VISIBLE(VIS_P), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .master_id(master_id),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata),
    .s_pready(s_pready), .s_pslverr(s_pslverr), .s_prdata(s_prdata),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata),
    .m_pready(m_pready), .m_pslverr(m_pslverr), .m_prdata(m_prdata)
  );

  always #5 clk = ~clk;

  int    total_cnt = 0;
  int    pass_cnt  = 0;
  string cur       = "init";

  logic [31:0] st_tab [SN][RN];
  logic [31:0] en_tab [SN][RN];
  logic [SN-1:0] vis_tab [MN];

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  mid;
    logic        wr;
    logic [31:0] wd;
    int          waits;      // >= TO means the slave never answers
    bit          drop;       // master drops psel at the first ACCESS cycle
    int          exp_slave;  // -1 means error response expected
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s.%s: actual=0x%0h required=0x%0h", cur, name, act, exp);
  endtask

  // Reference decode: first visible slave whose enabled range holds the address.
  function automatic int model_slave(input logic [31:0] a, input int mid);
    if (mid >= MN) return -1;
    for (int s = 0; s < SN; s++) begin
      if (vis_tab[mid][s]) begin
        for (int r = 0; r < RN; r++) begin
          if (en_tab[s][r] >= st_tab[s][r] && a >= st_tab[s][r] && a <= en_tab[s][r])
            return s;
        end
      end
    end
    return -1;
  endfunction

  task automatic check_idle();
    chk("idle_m_psel", 64'(m_psel), 64'd0);
    chk("idle_m_penable", 64'(m_penable), 64'd0);
    chk("idle_s_pready", 64'(s_pready), 64'd0);
    chk("idle_s_pslverr", 64'(s_pslverr), 64'd0);
    chk("idle_s_prdata", 64'(s_prdata), 64'd0);
  endtask

  task automatic do_xfer(input logic [31:0] a, input logic [1:0] mid, input logic wr,
                         input logic [31:0] wd, input int waits, input bit drop,
                         input int exp_slave);
    logic [SN-1:0]    oh;
    logic [SN*DW-1:0] rdv;
    logic [SN-1:0]    errv;
    bit               done, ready, tout;
    int               cycles;
    // T0: upstream setup in IDLE
    s_psel = 1'b1; s_penable = 1'b0; s_paddr = a; s_pwrite = wr;
    s_pwdata = wd; master_id = mid; m_pready = '0;
    #1;
    chk("t0_s_pready", 64'(s_pready), 64'd0);
    chk("t0_m_psel", 64'(m_psel), 64'd0);
    @(posedge clk); #1;
    s_penable = 1'b1;
    #1;
    if (exp_slave < 0) begin
      chk("err_m_psel", 64'(m_psel), 64'd0);
      chk("err_s_pready", 64'(s_pready), 64'd1);
      chk("err_s_pslverr", 64'(s_pslverr), 64'd1);
      chk("err_s_prdata", 64'(s_prdata), 64'd0);
      @(posedge clk); #1;
      s_psel = 1'b0; s_penable = 1'b0;
      #1;
      check_idle();
      $display("xfer %s addr=%08h mid=%0d -> error response", cur, a, mid);
      return;
    end
    oh = SN'(1) << exp_slave;
    chk("setup_m_psel", 64'(m_psel), 64'(oh));
    chk("setup_m_penable", 64'(m_penable), 64'd0);
    chk("setup_s_pready", 64'(s_pready), 64'd0);
    chk("setup_m_paddr", 64'(m_paddr), 64'(a));
    chk("setup_m_pwrite", 64'(m_pwrite), 64'(wr));
    chk("setup_m_pwdata", 64'(m_pwdata), 64'(wd));
    done = 1'b0;
    cycles = 0;
    for (int k = 0; k < TO && !done; k++) begin
      @(posedge clk); #1;
      if (drop && k == 0) begin s_psel = 1'b0; s_penable = 1'b0; end
      rdv  = {$urandom, $urandom, $urandom, $urandom, $urandom};
      errv = SN'($urandom);
      ready = (k == waits);
      tout  = !ready && (k == TO - 1);
      m_prdata  = rdv;
      m_pslverr = errv;
      m_pready  = (SN'($urandom) & ~oh) | (ready ? oh : '0);
      #1;
      chk("acc_m_psel", 64'(m_psel), 64'(oh));
      chk("acc_m_penable", 64'(m_penable), 64'd1);
      chk("acc_m_paddr", 64'(m_paddr), 64'(a));
      chk("acc_m_pwrite", 64'(m_pwrite), 64'(wr));
      chk("acc_m_pwdata", 64'(m_pwdata), 64'(wd));
      if (drop) begin
        chk("acc_s_pready", 64'(s_pready), 64'd0);
        chk("acc_s_pslverr", 64'(s_pslverr), 64'd0);
        chk("acc_s_prdata", 64'(s_prdata), 64'd0);
      end else if (tout) begin
        chk("to_s_pready", 64'(s_pready), 64'd1);
        chk("to_s_pslverr", 64'(s_pslverr), 64'd1);
        chk("to_s_prdata", 64'(s_prdata), 64'd0);
      end else begin
        chk("acc_s_pready", 64'(s_pready), 64'(ready));
        chk("acc_s_pslverr", 64'(s_pslverr), 64'(errv[exp_slave]));
        chk("acc_s_prdata", 64'(s_prdata), 64'(rdv[exp_slave*DW +: DW]));
      end
      done = ready || tout;
      cycles = k + 1;
    end
    @(posedge clk); #1;
    s_psel = 1'b0; s_penable = 1'b0; m_pready = '0;
    #1;
    check_idle();
    $display("xfer %s addr=%08h mid=%0d wr=%0d slave=%0d access_cycles=%0d%s",
             cur, a, mid, wr, exp_slave, cycles, drop ? " (dropped)" : "");
  endtask

  initial begin
    logic [SN*RN*AW-1:0] st_flat, en_flat;
    logic [MN*SN-1:0]    vis_flat;
    st_flat = START_P; en_flat = END_P; vis_flat = VIS_P;
    for (int s = 0; s < SN; s++)
      for (int r = 0; r < RN; r++) begin
        st_tab[s][r] = st_flat[(s*RN + r)*AW +: AW];
        en_tab[s][r] = en_flat[(s*RN + r)*AW +: AW];
      end
    for (int m = 0; m < MN; m++) vis_tab[m] = vis_flat[m*SN +: SN];

    //           addr           mid  wr    wdata         waits drop exp
    vecs[0]  = '{32'h0000_0010, 2'd0, 1'b0, 32'h0,         0, 1'b0,  0};
    vecs[1]  = '{32'h0003_0004, 2'd0, 1'b1, 32'hDEAD_BEEF, 3, 1'b0,  4};
    vecs[2]  = '{32'hFFFF_0000, 2'd0, 1'b0, 32'h0,         0, 1'b0, -1};
    vecs[3]  = '{32'h0004_0010, 2'd1, 1'b0, 32'h0,         0, 1'b0, -1};
    vecs[4]  = '{32'h0004_0010, 2'd0, 1'b1, 32'h1234_5678, 99, 1'b0, 3};
    vecs[5]  = '{32'h0000_8010, 2'd0, 1'b0, 32'h0,         1, 1'b0,  0};
    vecs[6]  = '{32'h0000_8010, 2'd1, 1'b0, 32'h0,         0, 1'b0,  0};
    vecs[7]  = '{32'h0000_8010, 2'd2, 1'b0, 32'h0,         0, 1'b0, -1};
    vecs[8]  = '{32'h0020_0000, 2'd0, 1'b0, 32'h0,         0, 1'b0, -1};
    vecs[9]  = '{32'h0010_0FFF, 2'd1, 1'b1, 32'hA5A5_0001, 1, 1'b0,  1};
    vecs[10] = '{32'h0010_1000, 2'd1, 1'b0, 32'h0,         0, 1'b0, -1};
    vecs[11] = '{32'h0060_0003, 2'd0, 1'b0, 32'h0,         2, 1'b0,  0};
    vecs[12] = '{32'h0060_0000, 2'd3, 1'b0, 32'h0,         0, 1'b0, -1};
    vecs[13] = '{32'h0001_FFFF, 2'd1, 1'b0, 32'h0,        15, 1'b0,  1};
    vecs[14] = '{32'h0002_0000, 2'd2, 1'b1, 32'h0BAD_F00D, 2, 1'b1,  2};
    vecs[15] = '{32'h0003_FFFF, 2'd2, 1'b0, 32'h0,         0, 1'b0,  4};

    rst = 1'b1; master_id = '0; s_psel = 1'b0; s_penable = 1'b0; s_pwrite = 1'b0;
    s_paddr = '0; s_pwdata = '0; m_pready = '0; m_pslverr = '0; m_prdata = '0;

    // Reset state
    cur = "reset";
    repeat (3) @(posedge clk);
    #1;
    check_idle();
    chk("m_paddr", 64'(m_paddr), 64'd0);
    chk("m_pwdata", 64'(m_pwdata), 64'd0);
    chk("m_pwrite", 64'(m_pwrite), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vector table
    foreach (vecs[i]) begin
      cur = $sformatf("vec%0d", i);
      do_xfer(vecs[i].addr, vecs[i].mid, vecs[i].wr, vecs[i].wd,
              vecs[i].waits, vecs[i].drop, vecs[i].exp_slave);
    end

    // Reset asserted in the middle of ACCESS
    cur = "rst_mid";
    s_psel = 1'b1; s_penable = 1'b0; s_paddr = 32'h0001_0020; master_id = 2'd0;
    s_pwrite = 1'b1; s_pwdata = 32'hCAFE_0001; m_pready = '0;
    @(posedge clk); #1;
    s_penable = 1'b1;
    @(posedge clk); #1;
    chk("in_access_m_penable", 64'(m_penable), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; s_psel = 1'b0; s_penable = 1'b0;
    #1;
    check_idle();
    chk("m_paddr", 64'(m_paddr), 64'd0);
    $display("xfer %s aborted by reset", cur);
    cur = "after_rst";
    do_xfer(32'h0001_0040, 2'd1, 1'b0, 32'h0, 1, 1'b0, 1);

    // Randomized traffic against the reference decode
    for (int n = 0; n < 40; n++) begin
      int s, r, waits;
      logic [31:0] a;
      logic [1:0]  mid;
      s = $urandom_range(0, SN-1);
      r = $urandom_range(0, RN-1);
      a = ($urandom_range(0, 3) == 0) ? $urandom : st_tab[s][r] + ($urandom & 32'h1FF);
      mid = 2'($urandom_range(0, 3));
      waits = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 4);
      cur = $sformatf("rnd%0d", n);
      do_xfer(a, mid, 1'($urandom), $urandom, waits, 1'b0, model_slave(a, int'(mid)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
